// File: rtl/spi_flash_xip_apb.sv
// APB slave serving 32-bit execute-in-place reads from SPI NOR flash (mode 0),
// with a single-word read cache in front of the SPI shifter.
module spi_flash_xip_apb #(
    parameter logic [31:0] FLASH_BASE   = 32'h3000_0000,
    parameter logic [31:0] FLASH_MASK   = 32'h0fff_ffff,
    parameter logic [7:0]  READ_CMD     = 8'h03,
    parameter int unsigned ADDR_BYTES   = 3,
    parameter int unsigned DUMMY_CYCLES = 0,
    parameter int unsigned SCK_DIV      = 1,
    parameter int unsigned SS_NUM       = 8,
    parameter int unsigned FLASH_SS     = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [31:0]       in_paddr,
    input  logic              in_psel,
    input  logic              in_penable,
    input  logic [2:0]        in_pprot,
    input  logic              in_pwrite,
    input  logic [31:0]       in_pwdata,
    input  logic [3:0]        in_pstrb,
    output logic              in_pready,
    output logic [31:0]       in_prdata,
    output logic              in_pslverr,
    input  logic              cache_flush,
    output logic              spi_sck,
    output logic [SS_NUM-1:0] spi_ss,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int unsigned AW    = 8 * ADDR_BYTES;
    localparam int unsigned TW    = 8 + AW;
    localparam int unsigned NBITS = TW + DUMMY_CYCLES + 32;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, DONE, RESP} state_t;

    state_t state, state_nx;

    logic [TW-1:0]   tx;
    logic [31:0]     rx;
    logic [7:0]      div_cnt;
    logic [6:0]      bit_cnt;
    logic            phase;
    logic            ss_n;
    logic            flush_seen;
    logic            cache_valid;
    logic [AW-3:0]   cache_tag;
    logic [AW-3:0]   req_tag;
    logic [31:0]     cache_data;

    logic            req;
    logic            bad;
    logic            hit;
    logic            half_end;
    logic            last_bit;
    logic [31:0]     word;
    logic            unused_apb;

    assign req        = in_psel & in_penable & ~in_pready;
    assign bad        = in_pwrite | ((in_paddr & ~FLASH_MASK) != FLASH_BASE);
    assign hit        = cache_valid & (cache_tag == in_paddr[AW-1:2]);
    assign half_end   = (div_cnt == 8'(SCK_DIV));
    assign last_bit   = (bit_cnt == 7'(NBITS - 1));
    // First flash byte arrives in rx[31:24] and belongs in the low lane.
    assign word       = {rx[7:0], rx[15:8], rx[23:16], rx[31:24]};
    assign spi_mosi   = tx[TW-1];
    assign unused_apb = ^{in_pprot, in_pwdata, in_pstrb};

    always_comb begin
        spi_ss           = '1;
        spi_ss[FLASH_SS] = ss_n;
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req) state_nx = (bad || hit) ? RESP : SETUP;
            SETUP:   state_nx = SHIFT;
            SHIFT:   if (half_end && phase && last_bit) state_nx = DONE;
            DONE:    state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            in_pready   <= 1'b0;
            in_prdata   <= '0;
            in_pslverr  <= 1'b0;
            spi_sck     <= 1'b0;
            ss_n        <= 1'b1;
            tx          <= '0;
            rx          <= '0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            phase       <= 1'b0;
            flush_seen  <= 1'b0;
            cache_valid <= 1'b0;
            cache_tag   <= '0;
            req_tag     <= '0;
            cache_data  <= '0;
        end else begin
            in_pready  <= 1'b0;
            in_prdata  <= '0;
            in_pslverr <= 1'b0;
            flush_seen <= flush_seen | cache_flush;
            if (cache_flush) cache_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (bad) begin
                            in_pready  <= 1'b1;
                            in_pslverr <= 1'b1;
                        end else if (hit) begin
                            in_pready <= 1'b1;
                            in_prdata <= cache_data;
                        end else begin
                            ss_n       <= 1'b0;
                            tx         <= {READ_CMD, in_paddr[AW-1:2], 2'b00};
                            req_tag    <= in_paddr[AW-1:2];
                            div_cnt    <= '0;
                            bit_cnt    <= '0;
                            phase      <= 1'b0;
                            flush_seen <= cache_flush;
                        end
                    end
                end
                SHIFT: begin
                    if (half_end) begin
                        div_cnt <= '0;
                        phase   <= ~phase;
                        if (!phase) begin
                            spi_sck <= 1'b1;
                            rx      <= {rx[30:0], spi_miso};
                        end else begin
                            spi_sck <= 1'b0;
                            tx      <= {tx[TW-2:0], 1'b0};
                            bit_cnt <= bit_cnt + 7'd1;
                            if (last_bit) ss_n <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                DONE: begin
                    in_pready <= 1'b1;
                    in_prdata <= word;
                    // A flush seen at any point of this miss keeps the word out of the cache.
                    if (!flush_seen && !cache_flush) begin
                        cache_valid <= 1'b1;
                        cache_tag   <= req_tag;
                        cache_data  <= word;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
